// File: rtl/nickel_change_dispenser.sv
// Nickel change dispenser: fires one solenoid pulse per nickel, confirms each with the coin-drop sensor, retries misses, latches a jam.
// Optional NICKEL_REQ_FIFO_EN: 4-deep queue for requests arriving while busy, with req_drop on overflow.
module nickel_change_dispenser #(
  parameter int unsigned PULSE_CYCLES  = 4,
  parameter int unsigned SENSE_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned MAX_RETRY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [3:0] change_count,
  input  logic       coin_seen,
  output logic       solenoid,
  output logic       busy,
  output logic       done,
  output logic       jam,
  output logic [3:0] nickels_left,
  output logic [7:0] total_dispensed
`ifdef NICKEL_REQ_FIFO_EN
  ,
  output logic       req_drop
`endif
);

  localparam logic [7:0] PulseLast = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] SenseLast = 8'(SENSE_TIMEOUT - 1);
  localparam logic [7:0] GapLast   = 8'(GAP_CYCLES - 1);
  localparam logic [2:0] RetryMax  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_FIRE, S_SENSE, S_GAP, S_DONE, S_JAM} state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] left_q, left_d;
  logic [7:0] total_q, total_d;
  logic [2:0] retry_q, retry_d;
  logic       seen_q, seen_d;
  logic [2:0] retry_inc;
  logic       start_vld;
  logic [3:0] start_cnt;

  assign retry_inc = retry_q + 3'd1;

`ifdef NICKEL_REQ_FIFO_EN
  logic [3:0] fifo_mem_q [4];
  logic [1:0] fifo_wr_q, fifo_rd_q;
  logic [2:0] fifo_cnt_q;
  logic       fifo_empty, fifo_full, fifo_accept, fifo_push, fifo_pop, drop_q;

  assign fifo_empty  = (fifo_cnt_q == 3'd0);
  assign fifo_full   = (fifo_cnt_q == 3'd4);
  // An empty queue in DONE hands a same-cycle request straight to the launcher instead of queueing it.
  assign fifo_accept = change_valid && (state_q != S_IDLE) && (state_q != S_JAM) &&
                       !((state_q == S_DONE) && fifo_empty);
  assign fifo_push   = fifo_accept && !fifo_full;
  assign fifo_pop    = (state_q == S_DONE) && !fifo_empty;
  assign start_vld   = ((state_q == S_IDLE) && change_valid) ||
                       ((state_q == S_DONE) && (!fifo_empty || change_valid));
  assign start_cnt   = fifo_empty ? change_count : fifo_mem_q[fifo_rd_q];
  assign req_drop    = drop_q;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[fifo_wr_q] <= change_count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_wr_q  <= 2'd0;
      fifo_rd_q  <= 2'd0;
      fifo_cnt_q <= 3'd0;
      drop_q     <= 1'b0;
    end else begin
      drop_q     <= fifo_accept && fifo_full;
      if (fifo_push) fifo_wr_q <= fifo_wr_q + 2'd1;
      if (fifo_pop)  fifo_rd_q <= fifo_rd_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_q + 3'(fifo_push) - 3'(fifo_pop);
    end
  end
`else
  assign start_vld = (state_q == S_IDLE) && change_valid;
  assign start_cnt = change_count;
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    left_d   = left_q;
    total_d  = total_q;
    retry_d  = retry_q;
    seen_d   = seen_q;
    solenoid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    jam      = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_FIRE: begin
        solenoid = 1'b1;
        if (coin_seen) seen_d = 1'b1;
        if (timer_q == PulseLast) begin
          timer_d = 8'd0;
          state_d = S_SENSE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_SENSE: begin
        // A coin wins over a timeout landing on the same cycle.
        if (coin_seen || seen_q) begin
          seen_d  = 1'b0;
          left_d  = left_q - 4'd1;
          total_d = (total_q == 8'hFF) ? total_q : total_q + 8'd1;
          retry_d = 3'd0;
          timer_d = 8'd0;
          state_d = (left_q == 4'd1) ? S_DONE : S_GAP;
        end else if (timer_q == SenseLast) begin
          timer_d = 8'd0;
          retry_d = retry_inc;
          state_d = (retry_inc <= RetryMax) ? S_GAP : S_JAM;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_GAP: begin
        if (timer_q == GapLast) begin
          timer_d = 8'd0;
          seen_d  = 1'b0;
          state_d = S_FIRE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_JAM:   jam = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // A zero-nickel request still produces its done pulse.
    if (start_vld) begin
      timer_d = 8'd0;
      retry_d = 3'd0;
      seen_d  = 1'b0;
      if (start_cnt == 4'd0) begin
        state_d = S_DONE;
      end else begin
        left_d  = start_cnt;
        state_d = S_FIRE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= 8'd0;
      left_q  <= 4'd0;
      total_q <= 8'd0;
      retry_q <= 3'd0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      left_q  <= left_d;
      total_q <= total_d;
      retry_q <= retry_d;
      seen_q  <= seen_d;
    end
  end

  assign nickels_left    = left_q;
  assign total_dispensed = total_q;

endmodule
